job_sequencer: RTL and testbench

JOB_SEQUENCER -- requirements
Module: job_sequencer

---
 rtl/job_sequencer.sv | 101 ++++++++++
 tb/tb_job_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/job_sequencer.sv
// job_sequencer: hands one job at a time from an upstream valid/ready source to a
// control FSM, waits for its completion flag, and presents the result downstream.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   in_valid     upstream job request        in_ready   accepting a job (IDLE only)
//   in_data      job operand                 x_out      operand held for the datapath
//   w            one-cycle start pulse       done       completion flag from control FSM
//   res_in       datapath result             out_valid  result available downstream
//   out_ready    downstream accepts result   out_data   captured result
//   busy         not IDLE                    timeout    sticky abort flag
//   timeout_clr  clears timeout              job_count  completed jobs, wraps at 256
module job_sequencer #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 32  // legal range 2..255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] x_out,
  output logic              w,
  input  logic              done,
  input  logic [DATA_W-1:0] res_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              timeout,
  input  logic              timeout_clr,
  output logic [7:0]        job_count
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

  localparam logic [7:0] TimerLast = 8'(TIMEOUT - 1);

  state_e            state_q;
  logic [7:0]        timer_q;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] res_q;
  logic              timeout_q;
  logic [7:0]        count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      timer_q   <= 8'd0;
      x_q       <= '0;
      res_q     <= '0;
      timeout_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      // An abort below is assigned later in this block, so it overrides the clear.
      if (timeout_clr) timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            x_q     <= in_data;
            state_q <= StStart;
          end
        end
        StStart: begin
          timer_q <= 8'd0;
          state_q <= StWait;
        end
        StWait: begin
          // Completion wins over expiry on the last WAIT cycle.
          if (done) begin
            res_q   <= res_in;
            state_q <= StHold;
          end else if (timer_q == TimerLast) begin
            timeout_q <= 1'b1;
            state_q   <= StIdle;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        StHold: begin
          if (out_ready) begin
            count_q <= count_q + 8'd1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Handshake outputs are pure state decodes, so they cannot glitch on inputs.
  assign in_ready  = (state_q == StIdle);
  assign w         = (state_q == StStart);
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q != StIdle);
  assign x_out     = x_q;
  assign out_data  = res_q;
  assign timeout   = timeout_q;
  assign job_count = count_q;

endmodule

// File: tb/tb_job_sequencer.sv
module tb_job_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] x_out;
  logic       w;
  logic       done;
  logic [7:0] res_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;
  logic       timeout;
  logic       timeout_clr;
  logic [7:0] job_count;

  int n_checks = 0;
  int n_fail   = 0;
  int w_dbl    = 0;
  logic w_prev = 1'b0;

  always #5 clk = ~clk;

  job_sequencer #(.DATA_W(8), .TIMEOUT(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .x_out(x_out), .w(w), .done(done), .res_in(res_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .timeout(timeout),
    .timeout_clr(timeout_clr), .job_count(job_count)
  );

  // w must never be sampled high on two consecutive cycles.
  always @(negedge clk) begin
    if (w && w_prev) w_dbl++;
    w_prev = w;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge; inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_inrdy"}, in_ready, 1);
    check({tag, "_w"}, w, 0);
    check({tag, "_ovld"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_tmo"}, timeout, 0);
    check({tag, "_cnt"}, job_count, 0);
    check({tag, "_x"}, x_out, 0);
    check({tag, "_odata"}, out_data, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; done = 1'b0; res_in = 8'h00;
    out_ready = 1'b0; timeout_clr = 1'b0;
    @(negedge clk);
    check_reset_vals("rst0");
    rst = 1'b0;

    // Basic job: done two cycles after w.
    accept(8'h5A);
    check("j1_w", w, 1);
    check("j1_x", x_out, 8'h5A);
    check("j1_inrdy", in_ready, 0);
    check("j1_busy", busy, 1);
    tick();
    check("j1_w_low", w, 0);
    tick();
    done = 1'b1; res_in = 8'hC3;
    tick();
    done = 1'b0;
    check("j1_ovld", out_valid, 1);
    check("j1_odata", out_data, 8'hC3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("j1_ovld_off", out_valid, 0);
    check("j1_cnt", job_count, 1);
    check("j1_idle", in_ready, 1);

    // Timeout: 32 WAIT cycles without done.
    accept(8'h01);
    tick();  // first WAIT cycle, timer 0
    repeat (31) tick();
    check("to_busy_last", busy, 1);
    check("to_tmo_early", timeout, 0);
    tick();
    check("to_busy", busy, 0);
    check("to_tmo", timeout, 1);
    check("to_ovld", out_valid, 0);
    check("to_cnt", job_count, 1);

    // Second abort coincident with timeout_clr: abort wins.
    accept(8'h02);
    tick();
    repeat (31) tick();
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check("toclr_prio", timeout, 1);
    check("toclr_busy", busy, 0);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check("toclr", timeout, 0);

    // HOLD back-pressure with noisy inputs.
    accept(8'h11);
    tick();
    done = 1'b1; res_in = 8'h77;
    tick();
    check("hold_ovld0", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; done = ~i[0]; res_in = 8'(i * 13); in_data = 8'(i + 8'hA0);
      tick();
      check("hold_ovld", out_valid, 1);
      check("hold_odata", out_data, 8'h77);
      check("hold_inrdy", in_ready, 0);
      check("hold_x", x_out, 8'h11);
    end
    in_valid = 1'b0; done = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_hs_ovld", out_valid, 0);
    check("hold_hs_cnt", job_count, 2);

    // done on the last WAIT cycle counts as completion.
    accept(8'h22);
    tick();
    repeat (31) tick();
    check("late_busy", busy, 1);
    done = 1'b1; res_in = 8'h99;
    tick();
    done = 1'b0;
    check("late_ovld", out_valid, 1);
    check("late_odata", out_data, 8'h99);
    check("late_tmo", timeout, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("late_cnt", job_count, 3);

    // Reset during WAIT.
    accept(8'h33);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_reset_vals("rstw");
    tick();
    rst = 1'b0;
    done = 1'b1; res_in = 8'hEE;
    tick();
    done = 1'b0;
    check("rstw_ign_busy", busy, 0);
    check("rstw_ign_ovld", out_valid, 0);
    check("rstw_ign_odata", out_data, 0);
    accept(8'h44);
    check("rstw_w", w, 1);
    check("rstw_x", x_out, 8'h44);
    tick();
    done = 1'b1; res_in = 8'h55;
    tick();
    done = 1'b0;
    check("rstw_odata", out_data, 8'h55);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("rstw_cnt", job_count, 1);

    // 256 back-to-back jobs from reset: 4 cycles per job.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h3C; done = 1'b1; res_in = 8'h5D; out_ready = 1'b1;
    repeat (255 * 4) tick();
    check("b2b_cnt255", job_count, 255);
    check("b2b_idle", in_ready, 1);
    repeat (4) tick();
    check("b2b_cnt0", job_count, 0);
    in_valid = 1'b0; done = 1'b0; out_ready = 1'b0;
    check("w_double", w_dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
